// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffer pipeline stage.
//   skid_state_e : occupancy state of the two-entry buffer
//   STALL_CNT_W  : width of the optional stall-cycle counter
package pipe_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_BUSY,
    SKID_FULL
  } skid_state_e;

  localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_skid_buffer_32bit.sv
// Two-entry valid/ready pipeline stage with a skid register. in_ready,
// out_valid and out_data are all registered, so a downstream stall never
// forms a combinational path back to the upstream stage.
//
// Ports:
//   clk        rising-edge clock
//   rst_ni     asynchronous active-low reset
//   flush      synchronous discard of all held beats
//   in_valid   upstream beat present
//   in_data    upstream payload
//   in_ready   buffer can accept a beat this cycle
//   out_valid  out_data holds a beat
//   out_data   payload from the main register
//   out_ready  downstream accepts the beat this cycle
//   stall_cnt  saturating count of out_valid & !out_ready cycles
//              (only when PIPE_SKID_STATS_EN is defined)
module pipe_skid_buffer_32bit
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             in_xfer, out_xfer;
  logic             load_main_in, load_main_skid, load_skid;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign out_data = main_q;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (in_xfer) begin
          load_main_in = 1'b1;
          state_d      = SKID_BUSY;
        end
      end
      SKID_BUSY: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_d   = SKID_FULL;
        end else if (out_xfer) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (out_ready) begin
          load_main_skid = 1'b1;
          state_d        = SKID_BUSY;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    // Flush wins over every transfer: the offered beat is dropped and
    // nothing is captured.
    if (flush) begin
      state_d        = SKID_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= SKID_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Handshake outputs decode the next state so they are registered
      // yet already reflect this edge's transfers.
      in_ready  <= (state_d != SKID_FULL);
      out_valid <= (state_d != SKID_EMPTY);
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

`ifdef PIPE_SKID_STATS_EN
  logic [STALL_CNT_W-1:0] stall_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_skid_buffer_32bit.sv
// Self-checking bench for pipe_skid_buffer_32bit. Beats accepted upstream
// are queued; beats delivered downstream are popped and compared. The
// queue depth also gives the expected in_ready/out_valid.
// Stall counter checks are active when PIPE_SKID_STATS_EN is defined.
module tb_pipe_skid_buffer_32bit;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
`ifdef PIPE_SKID_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt;
  int unsigned            stall_model = 0;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] sb_q[$];

  pipe_skid_buffer_32bit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_ni    (rst_ni),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: inputs are stable at the falling edge and show
  // what the next rising edge will see.
  always @(negedge clk) begin
    if (!rst_ni) begin
      sb_q.delete();
`ifdef PIPE_SKID_STATS_EN
      stall_model = 0;
`endif
    end else begin
      check_eq("out_valid", {31'b0, out_valid}, {31'b0, sb_q.size() > 0});
      check_eq("in_ready", {31'b0, in_ready}, {31'b0, sb_q.size() < 2});
`ifdef PIPE_SKID_STATS_EN
      check_eq("stall_cnt", {16'b0, stall_cnt}, stall_model);
      if (sb_q.size() > 0 && !out_ready && stall_model < 32'hFFFF) stall_model++;
`endif
      if (flush) begin
        sb_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) check_eq("unexpected_beat", out_data, 32'hXXXX_XXXX);
          else check_eq("out_data", out_data, sb_q.pop_front());
        end
        if (in_valid && in_ready) sb_q.push_back(in_data);
      end
    end
  end

  initial begin
    rst_ni    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("rst_out_data", out_data, 32'd0);
`ifdef PIPE_SKID_STATS_EN
    check_eq("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
`endif
    rst_ni = 1'b1;
    step();

    // Streaming: one-cycle latency, full throughput
    out_ready = 1'b1;
    for (int unsigned i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      step();
      check_eq("stream_lat", out_data, i);
      check_eq("stream_rdy", {31'b0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    step();

    // Backpressure: A in main, B in skid, C held off
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    in_data = 32'hB;
    step();
    check_eq("bp_full_rdy", {31'b0, in_ready}, 32'd0);
    in_data = 32'hC;
    step();
    step();
    check_eq("bp_hold_data", out_data, 32'hA);
    check_eq("bp_hold_rdy", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    check_eq("bp_rel_data", out_data, 32'hB);
    check_eq("bp_rel_rdy", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check_eq("bp_c_data", out_data, 32'hC);
    step();
    step();

    // Simultaneous in/out while BUSY
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h10;
    step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    step();
    in_valid = 1'b0;
    check_eq("sim_data", out_data, 32'h11);
    check_eq("sim_valid", {31'b0, out_valid}, 32'd1);
    step();
    step();

    // Flush while FULL with a beat offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h20;
    step();
    in_data = 32'h21;
    step();
    flush   = 1'b1;
    in_data = 32'h55;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_valid", {31'b0, out_valid}, 32'd0);
    check_eq("flush_rdy", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (3) step();

`ifdef PIPE_SKID_STATS_EN
    // Saturation of the stall counter, then flush leaves it alone
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h77;
    step();
    in_valid = 1'b0;
    repeat (70000) step();
    check_eq("stall_sat", {16'b0, stall_cnt}, 32'hFFFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    check_eq("stall_flush", {16'b0, stall_cnt}, 32'hFFFF);
`endif

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    step();
    in_valid = 1'b0;
    check_eq("pre_rst_data", out_data, 32'hDEAD_BEEF);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("arst_valid", {31'b0, out_valid}, 32'd0);
    check_eq("arst_data", out_data, 32'd0);
    check_eq("arst_rdy", {31'b0, in_ready}, 32'd1);
`ifdef PIPE_SKID_STATS_EN
    check_eq("arst_stall", {16'b0, stall_cnt}, 32'd0);
`endif
    @(negedge clk);
    #1;
    rst_ni = 1'b1;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
